// File: rtl/harvard_mem_pkg.sv
// ============================================================================
// Module  : harvard_mem_pkg
// Brief   : Shared types, defaults and parity helper for Harvard-core memories.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

package harvard_mem_pkg;

  localparam int DEF_WIDTH = 16;
  localparam int DEF_DEPTH = 64;
  localparam int PAR_MAX_W = 64;

  typedef enum logic [0:0] {
    ST_CLEAR = 1'b0,
    ST_RUN   = 1'b1
  } mem_state_e;

  // Even parity: the returned bit makes the total number of ones even.
  function automatic logic even_parity(input logic [PAR_MAX_W-1:0] d);
    return ^d;
  endfunction

endpackage

`default_nettype wire

// File: rtl/harvard_mem_clr_seq.sv
// ============================================================================
// Module  : harvard_mem_clr_seq
// Brief   : Post-reset clear sequencer; sweeps every word once, then raises ready.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module harvard_mem_clr_seq
  import harvard_mem_pkg::*;
#(
  parameter int DEPTH = DEF_DEPTH,
  localparam int AW   = $clog2(DEPTH)
) (
  input  logic          clk_i,
  input  logic          rst_i,
  output logic          clr_we_o,
  output logic [AW-1:0] clr_addr_o,
  output logic          ready_o
);

  localparam logic [AW-1:0] LAST_ADDR = AW'(DEPTH - 1);

  mem_state_e    state_q;
  logic [AW-1:0] ptr_q;
  logic          ready_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= ST_CLEAR;
      ptr_q   <= '0;
      ready_q <= 1'b0;
    end else begin
      unique case (state_q)
        ST_CLEAR: begin
          if (ptr_q == LAST_ADDR) begin
            state_q <= ST_RUN;
            ready_q <= 1'b1;
          end else begin
            ptr_q <= ptr_q + AW'(1);
          end
        end
        ST_RUN: begin
          state_q <= ST_RUN;
        end
        default: state_q <= ST_CLEAR;
      endcase
    end
  end

  assign clr_we_o   = (state_q == ST_CLEAR);
  assign clr_addr_o = ptr_q;
  assign ready_o    = ready_q;

endmodule

`default_nettype wire

// File: rtl/harvard_data_ram.sv
// ============================================================================
// Module  : harvard_data_ram
// Brief   : Parametrised data RAM: registered read, write-first bypass,
//           hardware clear after reset, out-of-range detection.
// Config  : define DMEM_PARITY_EN to store a per-word parity bit and add perr_o.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module harvard_data_ram
  import harvard_mem_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int DEPTH = DEF_DEPTH,
  localparam int AW   = $clog2(DEPTH)
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             we_i,
  input  logic [AW-1:0]    wa_i,
  input  logic [WIDTH-1:0] wd_i,
  input  logic             re_i,
  input  logic [AW-1:0]    ra_i,
  output logic [WIDTH-1:0] rd_o,
  output logic             rvalid_o,
  output logic             ready_o,
  output logic             aerr_o
`ifdef DMEM_PARITY_EN
  ,
  output logic             perr_o
`endif
);

  localparam logic [AW:0] DEPTH_W = (AW + 1)'(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];

  logic             clr_we;
  logic [AW-1:0]    clr_addr;
  logic             ready;
  logic             wa_ok, ra_ok, wr_acc, rd_acc, user_we, bypass;
  logic             mem_we;
  logic [AW-1:0]    mem_addr;
  logic [WIDTH-1:0] mem_data;
  logic [WIDTH-1:0] rd_d, rd_q;
  logic             rvalid_d, rvalid_q, aerr_d, aerr_q;

  harvard_mem_clr_seq #(.DEPTH(DEPTH)) u_clr_seq (
    .clk_i      (clk_i),
    .rst_i      (rst_i),
    .clr_we_o   (clr_we),
    .clr_addr_o (clr_addr),
    .ready_o    (ready)
  );

  assign wa_ok   = ({1'b0, wa_i} < DEPTH_W);
  assign ra_ok   = ({1'b0, ra_i} < DEPTH_W);
  assign wr_acc  = we_i & ready;
  assign rd_acc  = re_i & ready;
  assign user_we = wr_acc & wa_ok;
  assign bypass  = user_we & rd_acc & ra_ok & (wa_i == ra_i);

  // The clear sweep owns the write port until ready; reset itself never writes.
  assign mem_we   = ~rst_i & (clr_we | user_we);
  assign mem_addr = clr_we ? clr_addr : wa_i;
  assign mem_data = clr_we ? '0 : wd_i;

  always_ff @(posedge clk_i) begin
    if (mem_we) mem_q[mem_addr] <= mem_data;
  end

  always_comb begin
    rd_d     = rd_q;
    rvalid_d = rd_acc;
    aerr_d   = (wr_acc & ~wa_ok) | (rd_acc & ~ra_ok);
    if (rd_acc) begin
      if (!ra_ok)      rd_d = '0;
      else if (bypass) rd_d = wd_i;
      else             rd_d = mem_q[ra_i];
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      rd_q     <= '0;
      rvalid_q <= 1'b0;
      aerr_q   <= 1'b0;
    end else begin
      rd_q     <= rd_d;
      rvalid_q <= rvalid_d;
      aerr_q   <= aerr_d;
    end
  end

  assign rd_o     = rd_q;
  assign rvalid_o = rvalid_q;
  assign ready_o  = ready;
  assign aerr_o   = aerr_q;

`ifdef DMEM_PARITY_EN
  logic                 par_q [DEPTH];
  logic [PAR_MAX_W-1:0] wd_ext;
  logic                 perr_d, perr_q;

  always_comb begin
    wd_ext              = '0;
    wd_ext[WIDTH-1:0]   = wd_i;
  end

  always_ff @(posedge clk_i) begin
    if (mem_we) par_q[mem_addr] <= clr_we ? 1'b0 : even_parity(wd_ext);
  end

  // Bypassed data never touched the array, so it cannot carry a stored error.
  assign perr_d = rd_acc & ra_ok & ~bypass & (par_q[ra_i] != (^mem_q[ra_i]));

  always_ff @(posedge clk_i) begin
    if (rst_i) perr_q <= 1'b0;
    else       perr_q <= perr_d;
  end

  assign perr_o = perr_q;
`endif

endmodule

`default_nettype wire

// File: tb/tb_harvard_data_ram.sv
// ============================================================================
// Module  : tb_harvard_data_ram
// Brief   : Self-checking bench: DEPTH=64 and DEPTH=48 instances with a
//           memory model and read scoreboard. Parity checks when DMEM_PARITY_EN.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_harvard_data_ram;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic        a_we, a_re, a_rvalid, a_ready, a_aerr, a_perr;
  logic [5:0]  a_wa, a_ra;
  logic [15:0] a_wd, a_rd;
  logic        b_we, b_re, b_rvalid, b_ready, b_aerr, b_perr;
  logic [5:0]  b_wa, b_ra;
  logic [15:0] b_wd, b_rd;

  harvard_data_ram #(.WIDTH(16), .DEPTH(64)) u_a (
    .clk_i(clk), .rst_i(rst), .we_i(a_we), .wa_i(a_wa), .wd_i(a_wd),
    .re_i(a_re), .ra_i(a_ra), .rd_o(a_rd), .rvalid_o(a_rvalid),
    .ready_o(a_ready), .aerr_o(a_aerr)
`ifdef DMEM_PARITY_EN
    , .perr_o(a_perr)
`endif
  );

  harvard_data_ram #(.WIDTH(16), .DEPTH(48)) u_b (
    .clk_i(clk), .rst_i(rst), .we_i(b_we), .wa_i(b_wa), .wd_i(b_wd),
    .re_i(b_re), .ra_i(b_ra), .rd_o(b_rd), .rvalid_o(b_rvalid),
    .ready_o(b_ready), .aerr_o(b_aerr)
`ifdef DMEM_PARITY_EN
    , .perr_o(b_perr)
`endif
  );

`ifndef DMEM_PARITY_EN
  assign a_perr = 1'b0;
  assign b_perr = 1'b0;
`endif

  int          n_cmp  = 0;
  int          n_fail = 0;
  logic [15:0] mdl     [2][64];
  bit          corrupt [2][64];
  logic [15:0] last_rd [2];
  bit          rdy     [2];
  int          dep     [2] = '{64, 48};
  logic [15:0] sb [$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic idle_all();
    a_we = 0; a_re = 0; a_wa = 0; a_ra = 0; a_wd = 0;
    b_we = 0; b_re = 0; b_wa = 0; b_ra = 0; b_wd = 0;
  endtask

  task automatic model_reset();
    for (int s = 0; s < 2; s++) begin
      for (int i = 0; i < 64; i++) begin
        mdl[s][i] = 16'h0;
        corrupt[s][i] = 1'b0;
      end
      last_rd[s] = 16'h0;
      rdy[s] = 1'b0;
    end
  endtask

  // One access cycle on DUT s; the other instance idles.
  task automatic cyc(input int s, input bit we, input int wa, input logic [15:0] wd,
                     input bit re, input int ra);
    bit acc_w, acc_r, wok, rok, byp, exp_aerr, exp_perr;
    logic [15:0] exp_rd, o_rd;
    logic o_rv, o_aerr, o_perr;
    wok = (wa < dep[s]);
    rok = (ra < dep[s]);
    acc_w = we && rdy[s];
    acc_r = re && rdy[s];
    byp = acc_w && wok && acc_r && rok && (wa == ra);
    exp_aerr = (acc_w && !wok) || (acc_r && !rok);
    exp_perr = acc_r && rok && !byp && corrupt[s][ra];
    if (acc_r) begin
      if (!rok)     exp_rd = 16'h0;
      else if (byp) exp_rd = wd;
      else          exp_rd = mdl[s][ra];
      sb.push_back(exp_rd);
    end
    if (acc_w && wok) begin
      mdl[s][wa] = wd;
      corrupt[s][wa] = 1'b0;
    end
    idle_all();
    if (s == 0) begin
      a_we = we; a_wa = 6'(wa); a_wd = wd; a_re = re; a_ra = 6'(ra);
    end else begin
      b_we = we; b_wa = 6'(wa); b_wd = wd; b_re = re; b_ra = 6'(ra);
    end
    @(posedge clk); #1;
    o_rd   = (s == 0) ? a_rd     : b_rd;
    o_rv   = (s == 0) ? a_rvalid : b_rvalid;
    o_aerr = (s == 0) ? a_aerr   : b_aerr;
    o_perr = (s == 0) ? a_perr   : b_perr;
    chk($sformatf("rvalid[%0d] ra=%0d", s, ra), 32'(o_rv), 32'(acc_r));
    if (acc_r && sb.size() > 0) begin
      exp_rd = sb.pop_front();
      chk($sformatf("rd[%0d] ra=%0d", s, ra), 32'(o_rd), 32'(exp_rd));
      last_rd[s] = exp_rd;
    end else begin
      chk($sformatf("rd_hold[%0d]", s), 32'(o_rd), 32'(last_rd[s]));
    end
    chk($sformatf("aerr[%0d]", s), 32'(o_aerr), 32'(exp_aerr));
`ifdef DMEM_PARITY_EN
    chk($sformatf("perr[%0d] ra=%0d", s, ra), 32'(o_perr), 32'(exp_perr));
`endif
    idle_all();
  endtask

  // Junk traffic on not-yet-ready instances: must never take effect.
  task automatic clear_edge(input bit chk_ready, input int e);
    idle_all();
    if (!rdy[0]) begin a_we = 1; a_wa = 3; a_wd = 16'hAAAA; a_re = 1; a_ra = 3; end
    if (!rdy[1]) begin b_we = 1; b_wa = 3; b_wd = 16'hAAAA; b_re = 1; b_ra = 3; end
    @(posedge clk); #1;
    if (!rdy[0]) chk("a_rvalid_in_clear", 32'(a_rvalid), 32'd0);
    if (!rdy[1]) chk("b_rvalid_in_clear", 32'(b_rvalid), 32'd0);
    if (chk_ready) begin
      if (!rdy[0] && a_ready) begin chk("a_ready_edge", 32'(e), 32'd64); rdy[0] = 1'b1; end
      if (!rdy[1] && b_ready) begin chk("b_ready_edge", 32'(e), 32'd48); rdy[1] = 1'b1; end
    end
    idle_all();
  endtask

  task automatic do_reset(input int pre);
    idle_all();
    rst = 1'b1;
    @(posedge clk); @(posedge clk); #1;
    model_reset();
    chk("rst_a_rd", 32'(a_rd), 32'd0);
    chk("rst_a_rvalid", 32'(a_rvalid), 32'd0);
    chk("rst_a_ready", 32'(a_ready), 32'd0);
    chk("rst_a_aerr", 32'(a_aerr), 32'd0);
    chk("rst_b_rd", 32'(b_rd), 32'd0);
    rst = 1'b0;
    if (pre > 0) begin
      for (int e = 1; e <= pre; e++) clear_edge(1'b0, e);
      chk("a_ready_mid_clear", 32'(a_ready), 32'd0);
      rst = 1'b1;
      @(posedge clk); #1;
      chk("a_ready_after_rst", 32'(a_ready), 32'd0);
      rst = 1'b0;
    end
    for (int e = 1; e <= 100 && !(rdy[0] && rdy[1]); e++) clear_edge(1'b1, e);
    if (!rdy[0]) chk("a_ready_timeout", 32'(a_ready), 32'd1);
    if (!rdy[1]) chk("b_ready_timeout", 32'(b_ready), 32'd1);
  endtask

  initial begin
    idle_all();
    model_reset();

    // Power-up clear, then every word reads zero; junk during clear had no effect.
    do_reset(0);
    for (int i = 0; i < 64; i++) cyc(0, 0, 0, 16'h0, 1, i);

    // Write then read, then hold.
    cyc(0, 1, 5, 16'hBEEF, 0, 0);
    cyc(0, 0, 0, 16'h0, 1, 5);
    cyc(0, 0, 0, 16'h0, 0, 0);
    cyc(0, 0, 0, 16'h0, 0, 0);

    // Write-first bypass, then a normal read of the same word.
    cyc(0, 1, 9, 16'h1234, 1, 9);
    cyc(0, 0, 0, 16'h0, 1, 9);
    cyc(0, 1, 10, 16'h5A5A, 1, 9);
    cyc(0, 0, 0, 16'h0, 1, 10);

    repeat (24) cyc(0, bit'($urandom_range(1)), int'($urandom_range(15)),
                    16'($urandom()), bit'($urandom_range(1)), int'($urandom_range(15)));

    // Out-of-range handling on the 48-word instance.
    cyc(1, 1, 2, 16'h1111, 0, 0);
    cyc(1, 1, 47, 16'h4747, 0, 0);
    cyc(1, 1, 50, 16'hFFFF, 1, 50);
    cyc(1, 0, 0, 16'h0, 0, 0);
    cyc(1, 1, 60, 16'h5555, 1, 55);
    cyc(1, 0, 0, 16'h0, 0, 0);
    cyc(1, 1, 47, 16'h00AB, 1, 63);
    cyc(1, 1, 63, 16'h0CD0, 1, 2);
    cyc(1, 1, 48, 16'h0EEE, 1, 47);
    for (int i = 0; i < 48; i++) cyc(1, 0, 0, 16'h0, 1, i);

    // Reset mid-clear restarts the sweep from the beginning.
    do_reset(20);
    cyc(0, 0, 0, 16'h0, 1, 5);
    cyc(0, 0, 0, 16'h0, 1, 9);
    cyc(1, 0, 0, 16'h0, 1, 47);

`ifdef DMEM_PARITY_EN
    cyc(0, 1, 7, 16'h00F0, 0, 0);
    cyc(0, 1, 8, 16'h00F0, 0, 0);
    u_a.mem_q[7][3] = ~u_a.mem_q[7][3];
    mdl[0][7] = mdl[0][7] ^ 16'h0008;
    corrupt[0][7] = 1'b1;
    cyc(0, 0, 0, 16'h0, 1, 7);
    cyc(0, 0, 0, 16'h0, 1, 8);
    cyc(0, 1, 7, 16'h00F0, 1, 7);
    cyc(0, 0, 0, 16'h0, 1, 7);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
